eth_tx_pkt_fifo: RTL and testbench



---
 rtl/eth_tx_pkt_fifo.sv | 165 ++++++++++++++++
 tb/tb_eth_tx_pkt_fifo.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/eth_tx_pkt_fifo.sv
// Store-and-forward AXI-Stream TX packet buffer in front of the Ethernet MAC.
// Frames are released only once complete and good; bad or oversize frames are rolled back.
module eth_tx_pkt_fifo #(
  parameter int DWIDTH          = 512,
  parameter int KEEP_WIDTH      = DWIDTH / 8,
  parameter int DEPTH           = 256,
  parameter int MAX_FRAME_BEATS = 144
) (
  input  logic                     eth_clk,
  input  logic                     eth_rst_n,
  input  logic                     i_axis_tvalid,
  input  logic                     i_axis_tlast,
  input  logic                     i_axis_tuser,
  input  logic [DWIDTH-1:0]        i_axis_tdata,
  input  logic [KEEP_WIDTH-1:0]    i_axis_tkeep,
  output logic                     o_axis_tready,
  output logic                     o_eth_axis_tx_tvalid,
  output logic                     o_eth_axis_tx_tlast,
  output logic [DWIDTH-1:0]        o_eth_axis_tx_tdata,
  output logic [KEEP_WIDTH-1:0]    o_eth_axis_tx_tkeep,
  output logic                     o_eth_axis_tx_tuser,
  input  logic                     i_eth_axis_tx_tready,
  output logic [15:0]              o_frame_cnt,
  output logic [15:0]              o_drop_cnt,
  output logic [$clog2(DEPTH):0]   o_level
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  localparam int BW = $clog2(MAX_FRAME_BEATS + 1);
  localparam int EW = DWIDTH + KEEP_WIDTH + 1;

  typedef enum logic {S_IDLE, S_FRAME} wr_state_t;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  wr_state_t       state, state_nxt;
  logic [EW-1:0]   mem [DEPTH];
  logic [PW-1:0]   wr_ptr, commit_ptr, rd_ptr, fetch_ptr;
  logic [PW-1:0]   level, free;
  logic [BW-1:0]   beat_cnt;
  logic            oversize, rdy_en;
  logic            accept, store, frame_end, drop;

  assign level   = wr_ptr - rd_ptr;
  assign free    = PW'(DEPTH) - level;
  assign o_level = level;

  // rdy_en keeps tready low until the first clock edge after reset release
  always_comb begin
    state_nxt     = state;
    o_axis_tready = 1'b0;
    case (state)
      S_IDLE: begin
        o_axis_tready = rdy_en & (free >= PW'(MAX_FRAME_BEATS));
        if (i_axis_tvalid && o_axis_tready && !i_axis_tlast) state_nxt = S_FRAME;
      end
      S_FRAME: begin
        o_axis_tready = rdy_en;
        if (i_axis_tvalid && o_axis_tready && i_axis_tlast) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  assign accept    = i_axis_tvalid & o_axis_tready;
  assign store     = accept & (beat_cnt < BW'(MAX_FRAME_BEATS));
  assign frame_end = accept & i_axis_tlast;
  assign drop      = frame_end & (i_axis_tuser | oversize | ~store);

  always_ff @(posedge eth_clk or negedge eth_rst_n) begin
    if (!eth_rst_n) state <= S_IDLE;
    else            state <= state_nxt;
  end

  always_ff @(posedge eth_clk or negedge eth_rst_n) begin
    if (!eth_rst_n) begin
      rdy_en      <= 1'b0;
      wr_ptr      <= '0;
      commit_ptr  <= '0;
      beat_cnt    <= '0;
      oversize    <= 1'b0;
      o_frame_cnt <= '0;
      o_drop_cnt  <= '0;
    end else begin
      rdy_en <= 1'b1;
      if (frame_end) begin
        beat_cnt <= '0;
        oversize <= 1'b0;
        if (drop) begin
          wr_ptr     <= commit_ptr;
          o_drop_cnt <= sat_inc16(o_drop_cnt);
        end else begin
          wr_ptr      <= wr_ptr + PW'(1);
          commit_ptr  <= wr_ptr + PW'(1);
          o_frame_cnt <= o_frame_cnt + 16'd1;
        end
      end else if (accept) begin
        if (store) begin
          wr_ptr   <= wr_ptr + PW'(1);
          beat_cnt <= beat_cnt + BW'(1);
        end else begin
          oversize <= 1'b1;
        end
      end
    end
  end

  always_ff @(posedge eth_clk) begin
    if (store) mem[wr_ptr[AW-1:0]] <= {i_axis_tlast, i_axis_tkeep, i_axis_tdata};
  end

  // p0: issue RAM read while the output/skid pair plus in-flight read has room
  logic          issue_p0, avail_p0, pop;
  logic [1:0]    held_p0;
  logic          vld_p1, skid_vld;
  logic [EW-1:0] ram_p1, skid_p1;

  assign pop      = o_eth_axis_tx_tvalid & i_eth_axis_tx_tready;
  assign avail_p0 = (fetch_ptr != commit_ptr);
  assign held_p0  = 2'(o_eth_axis_tx_tvalid) + 2'(skid_vld) + 2'(vld_p1) - 2'(pop);
  assign issue_p0 = avail_p0 & (held_p0 <= 2'd1);
  assign o_eth_axis_tx_tuser = 1'b0;

  // p1: registered RAM read
  always_ff @(posedge eth_clk) begin
    if (issue_p0) ram_p1 <= mem[fetch_ptr[AW-1:0]];
  end

  always_ff @(posedge eth_clk) begin
    if (vld_p1 && ((o_eth_axis_tx_tvalid && !pop) || skid_vld)) skid_p1 <= ram_p1;
  end

  // p2: output register with skid slot behind it
  always_ff @(posedge eth_clk or negedge eth_rst_n) begin
    if (!eth_rst_n) begin
      fetch_ptr            <= '0;
      rd_ptr               <= '0;
      vld_p1               <= 1'b0;
      skid_vld             <= 1'b0;
      o_eth_axis_tx_tvalid <= 1'b0;
      o_eth_axis_tx_tlast  <= 1'b0;
      o_eth_axis_tx_tkeep  <= '0;
      o_eth_axis_tx_tdata  <= '0;
    end else begin
      vld_p1 <= issue_p0;
      if (issue_p0) fetch_ptr <= fetch_ptr + PW'(1);
      if (pop)      rd_ptr    <= rd_ptr + PW'(1);
      if (!o_eth_axis_tx_tvalid || pop) begin
        if (skid_vld) begin
          {o_eth_axis_tx_tlast, o_eth_axis_tx_tkeep, o_eth_axis_tx_tdata} <= skid_p1;
          skid_vld <= vld_p1;
        end else begin
          o_eth_axis_tx_tvalid <= vld_p1;
          if (vld_p1) {o_eth_axis_tx_tlast, o_eth_axis_tx_tkeep, o_eth_axis_tx_tdata} <= ram_p1;
        end
      end else if (vld_p1) begin
        skid_vld <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_eth_tx_pkt_fifo.sv
// Randomized bench for eth_tx_pkt_fifo: frame-level reference model plus output scoreboard.
module tb_eth_tx_pkt_fifo;

  localparam int DW   = 512;
  localparam int KW   = 64;
  localparam int DEP  = 256;
  localparam int MAXB = 144;

  logic          clk;
  logic          rst_n;
  logic          in_valid, in_last, in_user, in_ready;
  logic [DW-1:0] in_data;
  logic [KW-1:0] in_keep;
  logic          out_valid, out_last, out_user, mac_rdy;
  logic [DW-1:0] out_data;
  logic [KW-1:0] out_keep;
  logic [15:0]   frame_cnt, drop_cnt;
  logic [8:0]    level;

  eth_tx_pkt_fifo #(.DWIDTH(DW), .KEEP_WIDTH(KW), .DEPTH(DEP), .MAX_FRAME_BEATS(MAXB)) dut (
    .eth_clk(clk), .eth_rst_n(rst_n),
    .i_axis_tvalid(in_valid), .i_axis_tlast(in_last), .i_axis_tuser(in_user),
    .i_axis_tdata(in_data), .i_axis_tkeep(in_keep), .o_axis_tready(in_ready),
    .o_eth_axis_tx_tvalid(out_valid), .o_eth_axis_tx_tlast(out_last),
    .o_eth_axis_tx_tdata(out_data), .o_eth_axis_tx_tkeep(out_keep),
    .o_eth_axis_tx_tuser(out_user), .i_eth_axis_tx_tready(mac_rdy),
    .o_frame_cnt(frame_cnt), .o_drop_cnt(drop_cnt), .o_level(level)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int           n_checks = 0;
  int           n_pass   = 0;
  logic [576:0] exp_mem [4096];
  int           wr_i = 0, rd_i = 0;
  logic [15:0]  exp_frames = 0, exp_drops = 0;
  int           cyc = 0, beats_out = 0, budget = 0, mac_mode = 0;
  int           hs_cyc [8192];
  int           rise_cyc = -1, acc_edge = 0, mark = 0;
  bit           prev_stall = 0, prev_valid = 0;
  logic [576:0] prev_beat, cur;

  task automatic chk(input string tag, input logic [639:0] got, input logic [639:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  function automatic logic [511:0] rnd512();
    logic [511:0] r;
    for (int i = 0; i < 16; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  // Reference: a frame is forwarded intact iff tuser=0 on tlast and length <= MAXB.
  task automatic send_frame(input int n, input bit user, input int gap_pct,
                            input bit fix_keep, input logic [63:0] keep_val, input int rst_at);
    logic [576:0] fr[$];
    logic [511:0] d;
    logic [63:0]  k;
    int           w;
    for (int b = 1; b <= n; b++) begin
      d = rnd512();
      k = fix_keep ? keep_val : {$urandom, $urandom};
      @(negedge clk);
      while (gap_pct > 0 && $urandom_range(0, 99) < gap_pct) begin
        in_valid = 1'b0;
        @(negedge clk);
      end
      in_valid = 1'b1; in_data = d; in_keep = k; in_last = (b == n);
      in_user  = (b == n) ? user : 1'($urandom_range(0, 1));
      if (b == rst_at) begin
        #1 rst_n = 1'b0;
        #1;
        chk("rst_out_valid", 640'(out_valid), 640'(0));
        chk("rst_out_data", 640'(out_data), 640'(0));
        chk("rst_in_ready", 640'(in_ready), 640'(0));
        chk("rst_level", 640'(level), 640'(0));
        chk("rst_frame_cnt", 640'(frame_cnt), 640'(0));
        chk("rst_drop_cnt", 640'(drop_cnt), 640'(0));
        in_valid = 1'b0;
        @(negedge clk);
        #2 rst_n = 1'b1;
        rd_i = wr_i; exp_frames = 0; exp_drops = 0;
        return;
      end
      w = 0;
      while (!in_ready && w <= 4000) begin
        @(negedge clk);
        w++;
      end
      if (!in_ready) begin
        chk("in_ready_timeout", 640'(0), 640'(1));
        in_valid = 1'b0;
        return;
      end
      acc_edge = cyc + 1;
      fr.push_back({(b == n), k, d});
    end
    @(posedge clk);
    #1 in_valid = 1'b0;
    if (!user && n <= MAXB) begin
      foreach (fr[i]) begin
        exp_mem[wr_i % 4096] = fr[i];
        wr_i++;
      end
      exp_frames++;
    end else if (exp_drops != 16'hFFFF) begin
      exp_drops++;
    end
  endtask

  task automatic drain();
    int w = 0;
    while (rd_i != wr_i && w < 20000) begin
      @(negedge clk);
      w++;
    end
    if (rd_i != wr_i) begin
      chk("drain_timeout", 640'(rd_i), 640'(wr_i));
      rd_i = wr_i;
    end
    repeat (5) @(negedge clk);
  endtask

  task automatic wait_beats(input int target);
    int w = 0;
    while (beats_out < target && w < 2000) begin
      @(negedge clk);
      w++;
    end
    if (beats_out < target) chk("mac_drain_timeout", 640'(beats_out), 640'(target));
  endtask

  task automatic check_counts(input string tag);
    chk({tag, "_frame_cnt"}, 640'(frame_cnt), 640'(exp_frames));
    chk({tag, "_drop_cnt"}, 640'(drop_cnt), 640'(exp_drops));
    chk({tag, "_level"}, 640'(level), 640'(0));
  endtask

  initial begin
    rst_n = 1'b1; in_valid = 1'b0; in_last = 1'b0; in_user = 1'b0;
    in_data = '0; in_keep = '0; mac_rdy = 1'b1;
    fork
      forever @(posedge clk) cyc++;
      forever begin
        @(posedge clk);
        #2;
        case (mac_mode)
          0: mac_rdy = 1'b1;
          1: mac_rdy = ($urandom_range(0, 3) != 0);
          default: mac_rdy = (beats_out < budget);
        endcase
      end
      forever begin
        @(negedge clk);
        if (!rst_n) begin
          prev_stall = 0; prev_valid = 0;
        end else begin
          cur = {out_last, out_keep, out_data};
          if (prev_stall) begin
            chk("hold_valid", 640'(out_valid), 640'(1));
            chk("hold_beat", 640'(cur), 640'(prev_beat));
          end
          if (out_valid && !prev_valid) rise_cyc = cyc;
          if (out_valid && mac_rdy) begin
            if (rd_i == wr_i) chk("extra_beat", 640'(1), 640'(0));
            else begin
              chk("out_beat", 640'(cur), 640'(exp_mem[rd_i % 4096]));
              rd_i++;
            end
            hs_cyc[beats_out % 8192] = cyc;
            beats_out++;
          end
          prev_stall = out_valid && !mac_rdy;
          prev_valid = out_valid;
          prev_beat  = cur;
        end
      end
    join_none

    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_in_ready", 640'(in_ready), 640'(0));
    chk("reset_out_valid", 640'(out_valid), 640'(0));
    chk("reset_out_data", 640'({out_last, out_keep, out_data, out_user}), 640'(0));
    check_counts("reset");
    rst_n = 1'b1;
    #1 chk("ready_before_edge", 640'(in_ready), 640'(0));
    @(negedge clk);
    chk("ready_after_edge", 640'(in_ready), 640'(1));

    // single-beat frame and latency
    rise_cyc = -1;
    send_frame(1, 1'b0, 0, 1'b1, 64'h0000_0000_FFFF_FFFF, 0);
    drain();
    chk("single_latency", 640'(rise_cyc), 640'(acc_edge + 2));
    check_counts("single");

    // back-to-back 10 x 24, MAC always ready
    mark = beats_out;
    for (int f = 0; f < 10; f++) send_frame(24, 1'b0, 0, 1'b0, '0, 0);
    drain();
    chk("b2b_beats", 640'(beats_out - mark), 640'(240));
    chk("b2b_span", 640'(hs_cyc[(mark + 239) % 8192] - hs_cyc[mark % 8192]), 640'(239));
    check_counts("b2b");

    // error drop then good frame
    send_frame(5, 1'b1, 0, 1'b0, '0, 0);
    send_frame(3, 1'b0, 0, 1'b0, '0, 0);
    drain();
    check_counts("err_drop");

    // oversize drop then max-length frame
    send_frame(MAXB + 1, 1'b0, 0, 1'b0, '0, 0);
    send_frame(MAXB, 1'b0, 0, 1'b0, '0, 0);
    drain();
    check_counts("oversize");

    // randomized traffic with random gaps and MAC stalls
    mac_mode = 1;
    for (int f = 0; f < 25; f++)
      send_frame($urandom_range(1, 40), ($urandom_range(0, 7) == 0), 20, 1'b0, '0, 0);
    drain();
    mac_mode = 0;
    repeat (3) @(negedge clk);
    check_counts("random");

    // backpressure gating in IDLE
    budget = beats_out;
    mac_mode = 2;
    repeat (3) @(negedge clk);
    send_frame(120, 1'b0, 0, 1'b0, '0, 0);
    repeat (4) @(negedge clk);
    chk("bp_ready_low", 640'(in_ready), 640'(0));
    chk("bp_level_120", 640'(level), 640'(120));
    budget = beats_out + 7;
    wait_beats(budget);
    repeat (3) @(negedge clk);
    chk("bp_ready_low_7", 640'(in_ready), 640'(0));
    chk("bp_level_113", 640'(level), 640'(113));
    budget = beats_out + 1;
    wait_beats(budget);
    repeat (3) @(negedge clk);
    chk("bp_ready_high_8", 640'(in_ready), 640'(1));
    chk("bp_level_112", 640'(level), 640'(112));
    mac_mode = 0;
    send_frame(30, 1'b0, 0, 1'b0, '0, 0);
    drain();
    check_counts("backpressure");

    // reset in the middle of a frame
    send_frame(24, 1'b0, 0, 1'b0, '0, 10);
    repeat (3) @(negedge clk);
    check_counts("post_reset");
    send_frame(2, 1'b0, 0, 1'b0, '0, 0);
    drain();
    check_counts("after_reset");
    chk("tuser_zero", 640'(out_user), 640'(0));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
